ibex_rvfi_trace_fifo: RTL and testbench
=======================================

# ibex_rvfi_trace_fifo

Retirement-trace capture buffer that sits directly downstream of the tracing top level and consumes its RVFI retirement stream. Each retired instruction (`rvfi_valid`) is packed into a compact trace record and pushed into a circular buffer. A valid/ready port drains the buffer to an off-core trace sink. Retirements that arrive while the buffer is full or capture is disabled are dropped and counted, and the next stored record is flagged as following a discontinuity.

## Interface

**Parameters**

- `Depth`, 16: number of records; power of two, ≥ 2.
- `DropCntWidth`, 16: width of the saturating dropped-record counter.

**Ports**

- `clk_i` input 1: clock.
- `rst_i` input 1: reset, asynchronous, active-high.
- `rvfi_valid` input 1: instruction retired this cycle.
- `rvfi_insn` input 32: retired instruction word.
- `rvfi_trap` input 1: retirement trapped.
- `rvfi_intr` input 1: first instruction of a trap handler.
- `rvfi_pc_rdata` input 32: PC of the retired instruction.
- `rvfi_rd_addr` input 5: destination register; 0 means no write.
- `rvfi_rd_wdata` input 32: destination write data.
- `rvfi_mem_rmask` input 4: load byte mask.
- `rvfi_mem_wmask` input 4: store byte mask.
- `enable_i` input 1: capture enable.
- `flush_i` input 1: synchronous buffer and status clear.
- `trace_valid_o` output 1: head record available.
- `trace_ready_i` input 1: sink accepts the head record.
- `trace_pc_o` output 32: head record PC.
- `trace_insn_o` output 32: head record instruction.
- `trace_rd_addr_o` output 5: head record rd address.
- `trace_rd_wdata_o` output 32: head record rd data.
- `trace_flags_o` output 4: {gap, trap, intr, mem}.
- `level_o` output $clog2(Depth)+1: current number of stored records.
- `overflow_o` output 1: sticky flag, at least one retirement dropped because the buffer was full.
- `drop_cnt_o` output DropCntWidth: saturating count of dropped retirements.

## Operation

**Record format.** Each record stores pc, insn, rd_addr, rd_wdata and flags.
- `mem` = OR-reduce(`rvfi_mem_rmask` | `rvfi_mem_wmask`).
- `trap` and `intr` are copied from the inputs.
- `gap` = the `gap_pend` register value at push time.

**Storage.** Register array of `Depth` entries with write pointer, read pointer and count.
- Pointers are log2(Depth) bits and wrap naturally.
- Count is one bit wider.
- full = (count == Depth); empty = (count == 0).

**Push.** A push happens when `rvfi_valid` & `enable_i` & !full & !`flush_i`.
- Writes the record at the write pointer and increments the write pointer.
- Clears `gap_pend`.

**Drop on full.** When `rvfi_valid` & `enable_i` & full & !`flush_i`:
- The record is discarded and `overflow_o` is set.
- `drop_cnt_o` increments and saturates at all-ones.
- `gap_pend` is set.
- Full is evaluated on the registered count. A pop in the same cycle does not create room for that push (no bypass).

**Disabled capture.** When `rvfi_valid` & !`enable_i`:
- The record is discarded and `gap_pend` is set.
- Counters and `overflow_o` are unchanged.

**Pop.** A pop happens when `trace_valid_o` & `trace_ready_i` & !`flush_i`; it increments the read pointer.

**Simultaneous push and pop.** Both complete; count is unchanged.

**Flush.** `flush_i` has priority over push, pop and drop in the same cycle. It:
- zeroes both pointers and the count,
- clears `overflow_o` and `drop_cnt_o`,
- sets `gap_pend`, so the first record after a flush carries gap=1.

**Outputs.**
- `trace_valid_o` = !empty.
- Trace data outputs are read combinationally from the entry at the read pointer.
- Outputs are undefined-but-stable when empty. The bench must not check them while `trace_valid_o` is low.

## Timing

**Reset values.** Asserting `rst_i` immediately forces:
- pointers and count to 0,
- `trace_valid_o`, `level_o`, `overflow_o`, `drop_cnt_o` to 0,
- `gap_pend` to 0,
- storage contents to 0.

**Reset mid-operation.** Buffered records are lost; no drop is counted.

**Latency.**
- A record pushed in cycle N is visible with `trace_valid_o`=1 in cycle N+1.
- `level_o` reflects pushes and pops from the previous edge.

**Handshake.**
- `trace_valid_o` never deasserts without a pop or flush.
- Head data is stable while `trace_valid_o`=1 and `trace_ready_i`=0.

**Throughput.** One push and one pop per cycle sustained.

**Saturation.**
- `drop_cnt_o` holds at 2^DropCntWidth−1.
- `overflow_o` holds until flush or reset.

**Wrap-around.** Pointer wrap is transparent; ordering is strictly FIFO.

## Test plan

- **Basic capture.** After reset, 3 retirements with pc 0x100/0x104/0x108 and `trace_ready_i`=0 → `level_o`=3 and head pc=0x100 with flags=0. Then ready=1 → pcs 0x100, 0x104, 0x108 drain in order, one per cycle.
- **Full and drop.** Depth=16, ready=0, 20 retirements → `level_o`=16, `overflow_o`=1, `drop_cnt_o`=4. After draining 1 record and retiring 1 more → the 17th stored record has gap=1.
- **Simultaneous push/pop at full.** Full buffer, retirement and pop in the same cycle → retirement dropped, `drop_cnt_o`+1, `level_o`=15 next cycle.
- **Disable window.** `enable_i`=0 for 2 retirements → `level_o` and `drop_cnt_o` unchanged. Next enabled record has gap=1; the record after that has gap=0.
- **Flush priority.** Buffer with 5 records and `drop_cnt_o`=3; in one cycle assert `flush_i` together with a retirement and a pop → next cycle `level_o`=0, `trace_valid_o`=0, `overflow_o`=0, `drop_cnt_o`=0. The next record carries gap=1.
- **Flags, wrap and saturation.**
  - Store with wmask=0xF → mem=1.
  - Trap retirement → trap=1.
  - 40 push/pop pairs → FIFO order preserved across pointer wrap.
  - DropCntWidth=2 with 6 drops → `drop_cnt_o`=3.

Source files
------------

// File: rtl/ibex_rvfi_trace_fifo_if.sv
// Trace drain port between the retirement-trace buffer and an off-core sink.
// The buffer drives the head record and valid. The sink answers with ready.
interface ibex_rvfi_trace_fifo_if;
  logic        valid;
  logic        ready;
  logic [31:0] pc;
  logic [31:0] insn;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic [3:0]  flags;  // {gap, trap, intr, mem}

  modport master (
    output valid, pc, insn, rd_addr, rd_wdata, flags,
    input  ready
  );

  modport slave (
    input  valid, pc, insn, rd_addr, rd_wdata, flags,
    output ready
  );
endinterface

// File: rtl/ibex_rvfi_trace_fifo.sv
// Retirement-trace capture buffer.
// Packs each RVFI retirement into a compact record and stores it in a circular
// buffer, which is drained through a valid/ready port.
// Retirements are lost when the buffer is full or capture is off. Lost
// retirements are counted, and the next stored record is marked with the gap
// flag.
module ibex_rvfi_trace_fifo #(
  parameter int unsigned Depth        = 16,  // power of two, >= 2
  parameter int unsigned DropCntWidth = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  // RVFI retirement stream
  input  logic                      rvfi_valid,
  input  logic [31:0]               rvfi_insn,
  input  logic                      rvfi_trap,
  input  logic                      rvfi_intr,
  input  logic [31:0]               rvfi_pc_rdata,
  input  logic [4:0]                rvfi_rd_addr,
  input  logic [31:0]               rvfi_rd_wdata,
  input  logic [3:0]                rvfi_mem_rmask,
  input  logic [3:0]                rvfi_mem_wmask,
  // control
  input  logic                      enable_i,
  input  logic                      flush_i,
  // drain port
  ibex_rvfi_trace_fifo_if.master    trace,
  // status
  output logic [$clog2(Depth):0]    level_o,
  output logic                      overflow_o,
  output logic [DropCntWidth-1:0]   drop_cnt_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        gap;
    logic        trap;
    logic        intr;
    logic        mem;
  } rec_t;

  rec_t                    r_mem [Depth];
  logic [PtrW-1:0]         r_wptr;
  logic [PtrW-1:0]         r_rptr;
  logic [CntW-1:0]         r_count;
  logic                    r_gap_pend;
  logic                    r_overflow;
  logic [DropCntWidth-1:0] r_drop_cnt;

  logic w_full;
  logic w_empty;
  logic w_capture;
  logic w_push;
  logic w_drop;
  logic w_skip;
  logic w_pop;
  rec_t w_rec;
  rec_t w_head;

  // The full flag comes from the registered count only. A pop in the same
  // cycle does not free a slot for an incoming retirement.
  assign w_full    = (r_count == CntW'(Depth));
  assign w_empty   = (r_count == '0);
  assign w_capture = rvfi_valid & enable_i & ~flush_i;
  assign w_push    = w_capture & ~w_full;
  assign w_drop    = w_capture &  w_full;
  assign w_skip    = rvfi_valid & ~enable_i & ~flush_i;
  assign w_pop     = ~w_empty & trace.ready & ~flush_i;

  // Pack the incoming retirement into a trace record.
  always_comb begin
    // NOTE: give every always_comb output a value first, so that no path
    // through the block leaves it unassigned and infers a latch.
    w_rec          = '0;
    w_rec.pc       = rvfi_pc_rdata;
    w_rec.insn     = rvfi_insn;
    w_rec.rd_addr  = rvfi_rd_addr;
    w_rec.rd_wdata = rvfi_rd_wdata;
    w_rec.gap      = r_gap_pend;
    w_rec.trap     = rvfi_trap;
    w_rec.intr     = rvfi_intr;
    w_rec.mem      = |(rvfi_mem_rmask | rvfi_mem_wmask);
  end

  // Write the record into storage. The storage is also cleared on reset, so
  // the head outputs read back zero after reset and never show X.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: this reset loop is deliberate. Without it, a storage array is
    // usually left unreset.
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wptr] <= w_rec;
    end
  end

  // Pointers and occupancy. Flush takes priority over push and pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments only, so that every
    // flop samples the values from before the clock edge.
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Discontinuity marker. It is set by any lost retirement or by a flush, and
  // cleared by the next stored record.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_gap_pend <= 1'b0;
    end else if (flush_i) begin
      r_gap_pend <= 1'b1;
    end else if (w_push) begin
      r_gap_pend <= 1'b0;
    end else if (w_drop || w_skip) begin
      r_gap_pend <= 1'b1;
    end
  end

  // Overflow accounting. Only full-buffer drops count; disabled capture does
  // not.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (flush_i) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DropCntWidth'(1);
    end
  end

  // The head record is read combinationally at the read pointer.
  assign w_head         = r_mem[r_rptr];
  assign trace.valid    = ~w_empty;
  assign trace.pc       = w_head.pc;
  assign trace.insn     = w_head.insn;
  assign trace.rd_addr  = w_head.rd_addr;
  assign trace.rd_wdata = w_head.rd_wdata;
  assign trace.flags    = {w_head.gap, w_head.trap, w_head.intr, w_head.mem};

  assign level_o    = r_count;
  assign overflow_o = r_overflow;
  assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_ibex_rvfi_trace_fifo.sv
// Scoreboard bench for ibex_rvfi_trace_fifo.
// The main instance uses the default size. A second instance with Depth=2 and
// DropCntWidth=2 covers counter saturation. Both instances share the RVFI
// stream.
module tb_ibex_rvfi_trace_fifo;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [3:0]  flags;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] insn = '0;
  logic        trap = 1'b0;
  logic        intr = 1'b0;
  logic [31:0] pc = '0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] rd_wdata = '0;
  logic [3:0]  rmask = '0;
  logic [3:0]  wmask = '0;
  logic        en = 1'b1;
  logic        flush = 1'b0;
  logic        ready = 1'b0;
  logic        en2 = 1'b0;
  logic        flush2 = 1'b0;

  logic [4:0]  level;
  logic        ovf;
  logic [15:0] drop;
  logic [1:0]  level2;
  logic        ovf2;
  logic [1:0]  drop2;

  ibex_rvfi_trace_fifo_if trace_if ();
  ibex_rvfi_trace_fifo_if trace_if2 ();
  assign trace_if.ready  = ready;
  assign trace_if2.ready = 1'b0;

  always #5 clk = ~clk;

  ibex_rvfi_trace_fifo #(.Depth(16), .DropCntWidth(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .rvfi_valid(valid), .rvfi_insn(insn), .rvfi_trap(trap), .rvfi_intr(intr),
    .rvfi_pc_rdata(pc), .rvfi_rd_addr(rd_addr), .rvfi_rd_wdata(rd_wdata),
    .rvfi_mem_rmask(rmask), .rvfi_mem_wmask(wmask),
    .enable_i(en), .flush_i(flush), .trace(trace_if.master),
    .level_o(level), .overflow_o(ovf), .drop_cnt_o(drop)
  );

  ibex_rvfi_trace_fifo #(.Depth(2), .DropCntWidth(2)) dut2 (
    .clk_i(clk), .rst_i(rst),
    .rvfi_valid(valid), .rvfi_insn(insn), .rvfi_trap(trap), .rvfi_intr(intr),
    .rvfi_pc_rdata(pc), .rvfi_rd_addr(rd_addr), .rvfi_rd_wdata(rd_wdata),
    .rvfi_mem_rmask(rmask), .rvfi_mem_wmask(wmask),
    .enable_i(en2), .flush_i(flush2), .trace(trace_if2.master),
    .level_o(level2), .overflow_o(ovf2), .drop_cnt_o(drop2)
  );

  // reference model of the main instance
  rec_t        sb[$];
  logic        m_gap = 1'b0;
  logic        m_ovf = 1'b0;
  logic [15:0] m_drop = '0;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare the visible state of the main instance against the model.
  task automatic check_state();
    check("valid", trace_if.valid, sb.size() != 0);
    check("level", level, sb.size());
    check("overflow", ovf, m_ovf);
    check("drop_cnt", drop, m_drop);
    if (sb.size() != 0) begin
      check("head_pc", trace_if.pc, sb[0].pc);
      check("head_insn", trace_if.insn, sb[0].insn);
      check("head_rd_addr", trace_if.rd_addr, sb[0].rd_addr);
      check("head_rd_wdata", trace_if.rd_wdata, sb[0].rd_wdata);
      check("head_flags", trace_if.flags, sb[0].flags);
    end
  endtask

  // Check the current state, advance the model with the applied inputs, then
  // clock the design. Inputs change at posedge+1 and outputs are sampled there.
  task automatic tick();
    bit   full, pop, cap;
    rec_t r;
    check_state();
    if (flush) begin
      sb.delete();
      m_gap  = 1'b1;
      m_ovf  = 1'b0;
      m_drop = '0;
    end else begin
      full = (sb.size() == 16);
      pop  = (sb.size() != 0) && ready;
      cap  = valid && en;
      if (pop) void'(sb.pop_front());
      if (cap && !full) begin
        r.pc = pc; r.insn = insn; r.rd_addr = rd_addr; r.rd_wdata = rd_wdata;
        r.flags = {m_gap, trap, intr, |(rmask | wmask)};
        sb.push_back(r);
        m_gap = 1'b0;
      end else if (cap && full) begin
        m_ovf = 1'b1;
        if (m_drop != 16'hFFFF) m_drop++;
        m_gap = 1'b1;
      end else if (valid && !en) begin
        m_gap = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] p, input logic [31:0] i, input logic [4:0] rd,
                        input logic [31:0] wd, input logic [3:0] rm, input logic [3:0] wm,
                        input logic tp, input logic it);
    pc = p; insn = i; rd_addr = rd; rd_wdata = wd; rmask = rm; wmask = wm;
    trap = tp; intr = it; valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic retire_pc(input logic [31:0] p);
    retire(p, 32'h0000_0013, 5'd0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    // reset state, checked while reset is asserted
    #2;
    check("rst_valid", trace_if.valid, 1'b0);
    check("rst_level", level, 0);
    check("rst_overflow", ovf, 1'b0);
    check("rst_drop_cnt", drop, 0);
    check("rst_level2", level2, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // basic capture, then drain in order
    ready = 1'b0;
    retire_pc(32'h100); retire_pc(32'h104); retire_pc(32'h108);
    check("basic_level", level, 3);
    check("basic_head_pc", trace_if.pc, 32'h100);
    check("basic_head_flags", trace_if.flags, 4'h0);
    ready = 1'b1;
    idle(3);
    ready = 1'b0;

    // full and drop
    for (int k = 0; k < 20; k++) retire_pc(32'h1000 + 4 * k);
    check("full_level", level, 16);
    check("full_overflow", ovf, 1'b1);
    check("full_drop_cnt", drop, 4);
    ready = 1'b1; idle(1); ready = 1'b0;
    retire_pc(32'h2000);                    // stored with gap=1
    // retirement and pop in the same cycle at full: the retirement is dropped
    ready = 1'b1;
    retire_pc(32'h2004);
    check("pushpop_full_level", level, 15);
    check("pushpop_full_drop", drop, 5);
    idle(15);
    ready = 1'b0;

    // disable window
    en = 1'b0;
    retire_pc(32'h3000); retire_pc(32'h3004);
    check("dis_level", level, 0);
    check("dis_drop_cnt", drop, 5);
    en = 1'b1;
    retire_pc(32'h3008); retire_pc(32'h300C);
    check("dis_first_gap", trace_if.flags[3], 1'b1);
    ready = 1'b1; idle(1);
    check("dis_second_gap", trace_if.flags[3], 1'b0);
    idle(1);
    ready = 1'b0;

    // flush priority: 5 records stored and drop_cnt=3 before the flush
    flush = 1'b1; idle(1); flush = 1'b0;
    for (int k = 0; k < 19; k++) retire_pc(32'h4000 + 4 * k);
    ready = 1'b1; idle(11); ready = 1'b0;
    check("pre_flush_level", level, 5);
    check("pre_flush_drop", drop, 3);
    flush = 1'b1; ready = 1'b1;
    retire_pc(32'h5000);
    flush = 1'b0; ready = 1'b0;
    check("flush_level", level, 0);
    check("flush_valid", trace_if.valid, 1'b0);
    check("flush_overflow", ovf, 1'b0);
    check("flush_drop_cnt", drop, 0);
    retire_pc(32'h5004);
    check("flush_next_gap", trace_if.flags[3], 1'b1);
    ready = 1'b1; idle(1); ready = 1'b0;

    // record flags
    retire(32'h6000, 32'h00A5_2023, 5'd0, 32'h0, 4'h0, 4'hF, 1'b0, 1'b0);   // store
    retire(32'h6004, 32'h0000_0073, 5'd0, 32'h0, 4'h0, 4'h0, 1'b1, 1'b0);   // trap
    retire(32'h0800, 32'h3420_2573, 5'd10, 32'hB, 4'h0, 4'h0, 1'b0, 1'b1);  // handler entry
    retire(32'h0804, 32'h0005_2583, 5'd11, 32'hCAFE_F00D, 4'h1, 4'h0, 1'b0, 1'b0); // load
    check("store_mem_flag", trace_if.flags, 4'b0001);
    ready = 1'b1; idle(1);
    check("trap_flag", trace_if.flags, 4'b0100);
    idle(3);
    ready = 1'b0;

    // pointer wrap: 40 simultaneous push/pop pairs
    retire_pc(32'h7000);
    ready = 1'b1;
    for (int k = 0; k < 40; k++)
      retire($urandom, $urandom, 5'($urandom_range(0, 31)), $urandom,
             4'($urandom_range(0, 15)), 4'h0, 1'($urandom_range(0, 1)), 1'b0);
    check("wrap_level", level, 1);
    idle(1);
    ready = 1'b0;

    // saturation on the small instance; the main instance is disabled here
    en = 1'b0; flush2 = 1'b1; idle(1); flush2 = 1'b0; en2 = 1'b1;
    for (int k = 0; k < 4; k++) retire_pc(32'h8000 + 4 * k);
    check("sat_level2", level2, 2);
    check("sat_drop2_mid", drop2, 2);
    check("sat_ovf2", ovf2, 1'b1);
    for (int k = 0; k < 4; k++) retire_pc(32'h8100 + 4 * k);
    check("sat_drop2", drop2, 3);
    en2 = 1'b0; en = 1'b1;

    // reset in the middle of operation
    for (int k = 0; k < 3; k++) retire_pc(32'h9000 + 4 * k);
    rst = 1'b1;
    #1;
    check("midrst_level", level, 0);
    check("midrst_valid", trace_if.valid, 1'b0);
    check("midrst_drop", drop, 0);
    sb.delete(); m_gap = 1'b0; m_ovf = 1'b0; m_drop = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    retire_pc(32'hA000);
    check("postrst_flags", trace_if.flags, 4'h0);
    ready = 1'b1; idle(1); ready = 1'b0;
    check_state();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
